pc_redirect_unit: RTL and testbench

Parametrised next-PC generation stage for the RV32I pipeline. It owns the fetch PC register and arbitrates N redirect sources (branch resolve, JALR, trap/exception), a BTB prediction and sequential PC+4. It holds redirects that arrive during a fetch stall and drives the IF instruction mux to inject a configurable number of no-op bubbles after each redirect. It replaces fixed single-source PC mux selection.

---
 rtl/pc_redirect_if.sv | 29 ++
 rtl/pc_redirect_unit.sv | 85 ++++++++
 tb/tb_pc_redirect_unit.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pc_redirect_if.sv
// Fetch-side bundle for the next-PC stage: redirect/prediction inputs and PC/IF-mux outputs.
interface pc_redirect_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_SRC = 4
);
  localparam int unsigned SRCW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic                    stall_i;
  logic [NUM_SRC-1:0]      redir_valid_i;
  logic [NUM_SRC*XLEN-1:0] redir_pc_i;
  logic                    pred_valid_i;
  logic [XLEN-1:0]         pred_pc_i;
  logic [XLEN-1:0]         pc_o;
  logic [XLEN-1:0]         pc_plus4_o;
  logic                    ifmux_sel_o;
  logic                    redir_taken_o;
  logic [SRCW-1:0]         redir_src_o;
  logic                    pending_o;

  modport master (
    output stall_i, redir_valid_i, redir_pc_i, pred_valid_i, pred_pc_i,
    input  pc_o, pc_plus4_o, ifmux_sel_o, redir_taken_o, redir_src_o, pending_o
  );

  modport slave (
    input  stall_i, redir_valid_i, redir_pc_i, pred_valid_i, pred_pc_i,
    output pc_o, pc_plus4_o, ifmux_sel_o, redir_taken_o, redir_src_o, pending_o
  );
endinterface

// File: rtl/pc_redirect_unit.sv
// Next-PC stage: owns the fetch PC, arbitrates redirect sources against BTB and PC+4,
// parks redirects seen during a stall and injects flush bubbles into IF.
module pc_redirect_unit #(
  parameter int unsigned     XLEN          = 32,
  parameter int unsigned     NUM_SRC       = 4,
  parameter logic [XLEN-1:0] RESET_PC      = 32'h0000_0060,
  parameter int unsigned     FLUSH_BUBBLES = 2
) (
  input logic           clk,
  input logic           rst,
  pc_redirect_if.slave  bus
);
  localparam int unsigned SRCW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned CW   = (FLUSH_BUBBLES > 0) ? $clog2(FLUSH_BUBBLES + 1) : 1;
  localparam logic [XLEN-1:0] ALIGN = {{(XLEN-2){1'b1}}, 2'b00};

  logic [XLEN-1:0] pc_q;
  logic            pend_q;
  logic [SRCW-1:0] pend_idx_q;
  logic [XLEN-1:0] pend_pc_q;
  logic [CW-1:0]   cnt_q;
  logic            taken_q;
  logic [SRCW-1:0] src_q;

  logic            cand_v;
  logic [SRCW-1:0] cand_idx;
  logic [XLEN-1:0] cand_pc;

  // Ascending scan: first hit is the lowest index; at a given index the live
  // request is checked before the parked one so it wins the tie.
  always_comb begin
    cand_v   = 1'b0;
    cand_idx = '0;
    cand_pc  = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (!cand_v) begin
        if (bus.redir_valid_i[i]) begin
          cand_v   = 1'b1;
          cand_idx = SRCW'(i);
          cand_pc  = bus.redir_pc_i[i*XLEN +: XLEN] & ALIGN;
        end else if (pend_q && (pend_idx_q == SRCW'(i))) begin
          cand_v   = 1'b1;
          cand_idx = pend_idx_q;
          cand_pc  = pend_pc_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      pend_q     <= 1'b0;
      pend_idx_q <= '0;
      pend_pc_q  <= '0;
      cnt_q      <= '0;
      taken_q    <= 1'b0;
      src_q      <= '0;
    end else if (bus.stall_i) begin
      taken_q <= 1'b0;
      if (cand_v) begin
        pend_q     <= 1'b1;
        pend_idx_q <= cand_idx;
        pend_pc_q  <= cand_pc;
      end
    end else if (cand_v) begin
      pc_q    <= cand_pc;
      pend_q  <= 1'b0;
      taken_q <= 1'b1;
      src_q   <= cand_idx;
      cnt_q   <= CW'(FLUSH_BUBBLES);
    end else begin
      taken_q <= 1'b0;
      pc_q    <= bus.pred_valid_i ? (bus.pred_pc_i & ALIGN) : (pc_q + XLEN'(4));
      if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
    end
  end

  assign bus.pc_o          = pc_q;
  assign bus.pc_plus4_o    = pc_q + XLEN'(4);
  assign bus.ifmux_sel_o   = (cnt_q != '0);
  assign bus.redir_taken_o = taken_q;
  assign bus.redir_src_o   = src_q;
  assign bus.pending_o     = pend_q;
endmodule

// File: tb/tb_pc_redirect_unit.sv
// Vector-table bench for pc_redirect_unit: each record is one clock of stimulus plus
// the outputs expected just after that edge, routed through a scoreboard queue.
module tb_pc_redirect_unit;
  localparam int unsigned XLEN = 32;
  localparam int unsigned NS   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_redirect_if #(.XLEN(XLEN), .NUM_SRC(NS)) bus ();

  pc_redirect_unit #(
    .XLEN(XLEN), .NUM_SRC(NS), .RESET_PC(32'h0000_0060), .FLUSH_BUBBLES(2)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic        rst, stall;
    logic [3:0]  v;
    logic [31:0] p0, p1, p2, p3;
    logic        pv;
    logic [31:0] ppc;
    logic [31:0] e_pc;
    logic        e_mux, e_taken;
    logic [1:0]  e_src;
    logic        e_pend;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        mux, taken, chk_src;
    logic [1:0]  src;
    logic        pend;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic vec_t V(logic r, logic s, logic [3:0] v,
                             logic [31:0] p0, logic [31:0] p1, logic [31:0] p2, logic [31:0] p3,
                             logic pv, logic [31:0] ppc,
                             logic [31:0] epc, logic em, logic et, logic [1:0] es, logic ep);
    vec_t x;
    x.rst = r; x.stall = s; x.v = v;
    x.p0 = p0; x.p1 = p1; x.p2 = p2; x.p3 = p3;
    x.pv = pv; x.ppc = ppc;
    x.e_pc = epc; x.e_mux = em; x.e_taken = et; x.e_src = es; x.e_pend = ep;
    return x;
  endfunction

  task automatic check32(string name, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
  endtask

  task automatic step(vec_t x);
    exp_t e;
    @(negedge clk);
    rst               = x.rst;
    bus.stall_i       = x.stall;
    bus.redir_valid_i = x.v;
    bus.redir_pc_i    = {x.p3, x.p2, x.p1, x.p0};
    bus.pred_valid_i  = x.pv;
    bus.pred_pc_i     = x.ppc;
    e.pc = x.e_pc; e.mux = x.e_mux; e.taken = x.e_taken; e.src = x.e_src;
    e.pend = x.e_pend; e.chk_src = x.e_taken | x.rst;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check32("pc_o", bus.pc_o, e.pc);
    check32("pc_plus4_o", bus.pc_plus4_o, e.pc + 32'd4);
    check32("ifmux_sel_o", {31'd0, bus.ifmux_sel_o}, {31'd0, e.mux});
    check32("redir_taken_o", {31'd0, bus.redir_taken_o}, {31'd0, e.taken});
    check32("pending_o", {31'd0, bus.pending_o}, {31'd0, e.pend});
    if (e.chk_src) check32("redir_src_o", {30'd0, bus.redir_src_o}, {30'd0, e.src});
  endtask

  initial begin
    bus.stall_i = 1'b0; bus.redir_valid_i = '0; bus.redir_pc_i = '0;
    bus.pred_valid_i = 1'b0; bus.pred_pc_i = '0;

    // reset then sequential fetch
    tbl.push_back(V(1,0,4'b0000, 0,0,0,0, 0,0, 32'h60, 0,0,0,0));
    tbl.push_back(V(0,0,4'b0000, 0,0,0,0, 0,0, 32'h64, 0,0,0,0));
    tbl.push_back(V(0,0,4'b0000, 0,0,0,0, 0,0, 32'h68, 0,0,0,0));
    tbl.push_back(V(0,0,4'b0000, 0,0,0,0, 0,0, 32'h6C, 0,0,0,0));
    // two sources plus prediction: source 1 wins, two bubbles follow
    tbl.push_back(V(0,0,4'b0110, 0,32'h200,32'h300,0, 1,32'h400, 32'h200, 1,1,1,0));
    tbl.push_back(V(0,0,4'b0000, 0,0,0,0, 0,0, 32'h204, 1,0,0,0));
    tbl.push_back(V(0,0,4'b0000, 0,0,0,0, 0,0, 32'h208, 0,0,0,0));
    // stalled capture, lower index replaces, misaligned target forced aligned
    tbl.push_back(V(0,1,4'b0100, 0,0,32'h300,0, 0,0, 32'h208, 0,0,0,1));
    tbl.push_back(V(0,1,4'b0001, 32'h103,0,0,0, 0,0, 32'h208, 0,0,0,1));
    tbl.push_back(V(0,0,4'b0000, 0,0,0,0, 0,0, 32'h100, 1,1,0,0));
    tbl.push_back(V(0,0,4'b0000, 0,0,0,0, 0,0, 32'h104, 1,0,0,0));
    tbl.push_back(V(0,0,4'b0000, 0,0,0,0, 0,0, 32'h108, 0,0,0,0));
    // BTB prediction, no bubbles
    tbl.push_back(V(0,0,4'b0000, 0,0,0,0, 1,32'h400, 32'h400, 0,0,0,0));
    // wrap at top of address space
    tbl.push_back(V(0,0,4'b1000, 0,0,0,32'hFFFF_FFFF, 0,0, 32'hFFFF_FFFC, 1,1,3,0));
    tbl.push_back(V(0,0,4'b0000, 0,0,0,0, 0,0, 32'h0, 1,0,0,0));
    // stall holds bubble count; reset during stall drops pending redirect
    tbl.push_back(V(0,1,4'b0010, 0,32'h500,0,0, 0,0, 32'h0, 1,0,0,1));
    tbl.push_back(V(1,1,4'b0000, 0,0,0,0, 0,0, 32'h60, 0,0,0,0));
    tbl.push_back(V(0,0,4'b0000, 0,0,0,0, 0,0, 32'h64, 0,0,0,0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // bubble reload: a new redirect mid-flush restarts the count, not extends it
    step(V(0,0,4'b0001, 32'h800,0,0,0, 0,0, 32'h800, 1,1,0,0));
    step(V(0,0,4'b0000, 0,0,0,0, 0,0, 32'h804, 1,0,0,0));
    step(V(0,0,4'b0100, 0,0,32'h900,0, 0,0, 32'h900, 1,1,2,0));
    step(V(0,0,4'b0000, 0,0,0,0, 0,0, 32'h904, 1,0,0,0));
    step(V(0,0,4'b0000, 0,0,0,0, 0,0, 32'h908, 0,0,0,0));

    // live beats pending at the same index; prediction ignored while stalled
    step(V(0,1,4'b0010, 0,32'hA00,0,0, 0,0, 32'h908, 0,0,0,1));
    step(V(0,1,4'b0000, 0,0,0,0, 1,32'hE00, 32'h908, 0,0,0,1));
    step(V(0,0,4'b0010, 0,32'hB00,0,0, 1,32'hE00, 32'hB00, 1,1,1,0));
    step(V(0,0,4'b0000, 0,0,0,0, 0,0, 32'hB04, 1,0,0,0));
    step(V(0,0,4'b0000, 0,0,0,0, 0,0, 32'hB08, 0,0,0,0));

    // higher-index request during stall must not displace a lower-index pending one
    step(V(0,1,4'b0001, 32'hC00,0,0,0, 0,0, 32'hB08, 0,0,0,1));
    step(V(0,1,4'b0100, 0,0,32'hD00,0, 0,0, 32'hB08, 0,0,0,1));
    step(V(0,0,4'b0000, 0,0,0,0, 0,0, 32'hC00, 1,1,0,0));
    step(V(0,0,4'b0100, 0,0,32'hD00,0, 0,0, 32'hD00, 1,1,2,0));
    step(V(0,0,4'b0000, 0,0,0,0, 0,0, 32'hD04, 1,0,0,0));

    n_chk++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
